// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU package. Holds the state encoding of the
//                sequential multiplier FSM and the width of its iteration
//                counter.
//  Contents    : mul_state_e   - IDLE/RUN/DONE encodings
//                mul_cnt_width - counter width for a given operand MSB index
//                MUL_CNT_W     - counter width for the default 32-bit operands
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Enough bits to count W+1 iterations: ceil(log2(W+2)).
  function automatic int mul_cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

  localparam int MUL_W_DEFAULT = 31;
  localparam int MUL_CNT_W     = $clog2(MUL_W_DEFAULT + 2);

endpackage

`default_nettype wire

// File: rtl/mul_seq_if.sv
// ============================================================================
//  Module      : mul_seq_if
//  Description : Request/result bundle of the sequential multiplier.
//  Signals     : start              - request pulse (master -> slave)
//                A, B               - unsigned operands (master -> slave)
//                busy, done         - status (slave -> master)
//                product_lo/hi      - low/high halves of A*B (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_seq_if #(
  parameter int W = 31
);
  logic         start;
  logic [W:0]   A;
  logic [W:0]   B;
  logic         busy;
  logic         done;
  logic [W:0]   product_lo;
  logic [W:0]   product_hi;

  modport master (
    output start, A, B,
    input  busy, done, product_lo, product_hi
  );

  modport slave (
    input  start, A, B,
    output busy, done, product_lo, product_hi
  );
endinterface

`default_nettype wire

// File: rtl/mul_step.sv
// ============================================================================
//  Module      : mul_step
//  Description : One combinational shift-add iteration of the multiplier.
//                If the multiplier LSB (lo_i[0]) is set the multiplicand is
//                added to the upper accumulator half with a carry bit, then
//                {carry, hi, lo} is shifted right by one.
//  Ports       : hi_i, lo_i   - current accumulator halves (lo holds the
//                               not-yet-consumed multiplier bits)
//                mcand_i      - multiplicand
//                hi_o, lo_o   - accumulator halves after this iteration
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_step #(
  parameter int W = 31
) (
  input  wire logic [W:0] hi_i,
  input  wire logic [W:0] lo_i,
  input  wire logic [W:0] mcand_i,
  output logic      [W:0] hi_o,
  output logic      [W:0] lo_o
);

  logic [W+1:0] sum_w;

  always_comb begin
    sum_w = {1'b0, hi_i} + (lo_i[0] ? {1'b0, mcand_i} : {(W+2){1'b0}});
  end

  // The carry becomes the new MSB of hi; the bit leaving hi enters lo.
  assign hi_o = sum_w[W+1:1];
  assign lo_o = {sum_w[0], lo_i[W:1]};

endmodule

`default_nettype wire

// File: rtl/mul_seq.sv
// ============================================================================
//  Module      : mul_seq
//  Description : Sequential unsigned shift-add multiplier. A request accepted
//                in IDLE runs W+1 iterations in RUN, then raises done for one
//                cycle in DONE while the full 2(W+1)-bit product is presented
//                on product_hi/product_lo, which then hold until the next
//                completion.
//  Ports       : clk    - clock, rising edge
//                rst_n  - synchronous active-low reset
//                bus    - mul_seq_if slave: start/A/B in, busy/done/product out
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq
  import alu_pkg::*;
#(
  parameter int W = 31
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  mul_seq_if.slave   bus
);

  localparam int               CNT_W     = mul_cnt_width(W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W);

  mul_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W:0]       mcand_q;
  logic [W:0]       hi_q;
  logic [W:0]       lo_q;
  logic [W:0]       prod_hi_q;
  logic [W:0]       prod_lo_q;
  logic             busy_q;
  logic             done_q;

  logic [W:0]       step_hi;
  logic [W:0]       step_lo;

  mul_step #(.W(W)) u_step (
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .mcand_i (mcand_q),
    .hi_o    (step_hi),
    .lo_o    (step_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            mcand_q <= bus.A;
            hi_q    <= '0;
            lo_q    <= bus.B;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + 1'b1;
          // The edge finishing iteration W+1 publishes the step output
          // directly, so the product is valid in the same cycle as done.
          if (cnt_q == LAST_ITER) begin
            prod_hi_q <= step_hi;
            prod_lo_q <= step_lo;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.product_hi = prod_hi_q;
  assign bus.product_lo = prod_lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// ============================================================================
//  Module      : tb_mul_seq
//  Description : Self-checking bench for mul_seq. Expected products come from
//                plain 64-bit multiplication; expected latency is the fixed
//                W+1 = 32 edges from acceptance to done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq;

  localparam int W       = 31;
  localparam int LATENCY = W + 1;

  logic clk;
  logic rst_n;

  int checks;
  int failures;
  int lat;
  int busy_n;
  int both_high;
  int done_seen;

  mul_seq_if #(.W(W)) bus ();

  mul_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle; on return the accepting edge has
  // passed and lat/busy_n are restarted.
  task automatic start_job(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 0;
    busy_n    = 0;
    both_high = 0;
  endtask

  // Advances one cycle while recording busy and the busy/done overlap.
  task automatic tick();
    if (bus.busy) busy_n++;
    if (bus.busy && bus.done) both_high = 1;
    @(negedge clk);
    lat++;
  endtask

  task automatic run_to_done();
    while (!bus.done && lat < 60) tick();
  endtask

  // Checks the done cycle and the cycle after it against the model.
  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    check({tag, "_done"},    64'(bus.done), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(LATENCY));
    check({tag, "_busy_n"},  64'(busy_n), 64'(LATENCY));
    check({tag, "_overlap"}, 64'(both_high | (bus.busy & bus.done)), 64'd0);
    check({tag, "_hi"},      64'(bus.product_hi), 64'(prod[63:32]));
    check({tag, "_lo"},      64'(bus.product_lo), 64'(prod[31:0]));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
    check({tag, "_hold"}, {bus.product_hi, bus.product_lo}, prod);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    checks    = 0;
    failures  = 0;
    lat       = 0;
    busy_n    = 0;
    both_high = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_prod", {bus.product_hi, bus.product_lo}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", 64'({bus.busy, bus.done}), 64'd0);

    // Basic product
    start_job(32'd7, 32'd6);
    run_to_done();
    check_result("basic", 32'd7, 32'd6);

    // Full-scale product
    start_job(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_to_done();
    check_result("full", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Start held during RUN must not restart or recapture
    start_job(32'd3, 32'd5);
    repeat (5) begin
      bus.start = 1'b1;
      bus.A     = 32'd9;
      bus.B     = 32'd9;
      tick();
    end
    bus.start = 1'b0;
    run_to_done();
    check_result("busyrej", 32'd3, 32'd5);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen = 1;
    end
    check("busyrej_no_second_job", 64'(done_seen), 64'd0);

    // Reset in the middle of RUN
    start_job(32'h1234, 32'h10);
    repeat (10) tick();
    check("midrst_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_prod", {bus.product_hi, bus.product_lo}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      if (bus.done) done_seen = 1;
      @(negedge clk);
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);

    // Back-to-back: new start in the IDLE cycle right after done
    start_job(32'd2, 32'd3);
    run_to_done();
    check("b2b_first_done", 64'(bus.done), 64'd1);
    check("b2b_first_lo", 64'(bus.product_lo), 64'd6);
    @(negedge clk);
    check("b2b_idle", 64'({bus.busy, bus.done}), 64'd0);
    bus.start = 1'b1;
    bus.A     = 32'h1_0000;
    bus.B     = 32'h1_0000;
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 0;
    busy_n    = 0;
    both_high = 0;
    check("b2b_accepted", 64'(bus.busy), 64'd1);
    repeat (16) tick();
    check("b2b_lo_holds", 64'(bus.product_lo), 64'd6);
    run_to_done();
    check_result("b2b_second", 32'h1_0000, 32'h1_0000);

    // Zero operand still takes full latency
    start_job(32'd0, 32'hDEAD_BEEF);
    run_to_done();
    check_result("zero", 32'd0, 32'hDEAD_BEEF);

    // Random operands against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      start_job(ra, rb);
      run_to_done();
      check_result("rand", ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter W, default 31, MSB index of operand/result buses (data width W+1).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset; sampled only on rising clk edge.
REQ-004 start  in  1  request pulse; sampled on rising edge; accepted only in IDLE.
REQ-005 A  in  W+1  multiplicand, unsigned; captured on the accepting edge.
REQ-006 B  in  W+1  multiplier, unsigned; captured on the accepting edge.
REQ-007 busy  out  1  high while a multiply is in progress (state RUN).
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 product_lo  out  W+1  low half of A*B; feeds the ALU result select mux.
REQ-010 product_hi  out  W+1  high half of A*B.

Function
REQ-011 FSM states IDLE, RUN, DONE; the reset state is IDLE.
REQ-012 IDLE -> RUN on an edge with start=1; A and B are latched into internal working registers on the same edge.
REQ-013 IDLE with start=0 holds IDLE.
REQ-014 RUN performs one shift-add iteration per edge:
 - if the working multiplier LSB=1, add the multiplicand to the upper accumulator half with a (W+2)-bit carry;
 - then shift {carry, hi, lo} right by one.
REQ-015 The iteration counter is ceil(log2(W+2)) bits wide, cleared on entry to RUN, and incremented on each RUN edge.
REQ-016 RUN -> DONE on the edge that completes iteration W+1 (32nd for the default).
REQ-017 DONE -> IDLE unconditionally on the next edge.
REQ-018 Latency: done=1 for exactly one cycle, beginning W+1 edges after the accepting edge (32 for the default).
REQ-019 product_hi/product_lo load the final accumulator on the RUN->DONE edge only.
REQ-020 product_hi/product_lo hold their last value through IDLE, RUN and DONE until the next completion.
REQ-021 busy=1 exactly when the state is RUN; done=1 exactly when the state is DONE; the two are never both high.
REQ-022 start is ignored in RUN and DONE: no restart, no operand recapture, no effect on latency.
REQ-023 A start asserted in the cycle after done (state IDLE) is accepted, giving back-to-back operation with one idle edge between jobs.
REQ-024 The result is the exact 2(W+1)-bit unsigned product with no truncation; the maximal operands yield hi=2^(W+1)-2, lo=1.
REQ-025 A or B equal to 0 still takes the full latency and yields a zero product.

Reset
REQ-026 On an edge with rst_n=0:
 - state to IDLE;
 - busy=0 and done=0;
 - product_hi=0 and product_lo=0;
 - counter and working registers cleared.
REQ-027 Reset takes priority over start and over any state transition, including mid-RUN and during DONE; the aborted job produces no done pulse.
REQ-028 rst_n has no effect between clock edges.

Structure
REQ-029 FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width constant reside in the shared ALU package alu_pkg.
REQ-030 The per-iteration add-and-shift datapath is a single sub-module, mul_step: combinational, parameterised by W, taking {hi, lo, multiplicand} and returning the next {hi, lo}.
REQ-031 The FSM, counter and output registers reside in mul_seq; no other sub-modules.

Verification
REQ-032 Basic product: A=7, B=6, start for 1 cycle -> busy high for 32 cycles, then done for 1 cycle with product_lo=42, product_hi=0.
REQ-033 Full-scale product: A=B=0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001.
REQ-034 Busy rejection:
 - run A=3, B=5; during RUN assert start with A=9, B=9 for 5 cycles;
 - required: result 15, done exactly 32 edges after the first start, no second job.
REQ-035 Reset mid-run:
 - run A=0x1234, B=0x10; rst_n=0 for 1 cycle at iteration 10;
 - required: busy=0, product=0 next cycle, and no done pulse within 40 cycles.
REQ-036 Back-to-back:
 - done for A=2, B=3 (result 6); start with A=0x10000, B=0x10000 in the next (IDLE) cycle;
 - required: product_lo holds 6 during RUN, then product_hi=1, product_lo=0 at the second done.
REQ-037 Zero operand: A=0, B=0xDEADBEEF -> done after 32 cycles with both halves 0.
